// File: rtl/exec_seq_if.sv
// exec_seq_if: instruction handshake, memory port, ALU port and status of the sequencer
interface exec_seq_if #(
    parameter int INST_LEN  = 17,
    parameter int WORD_SIZE = 32,
    parameter int ADDR_LEN  = 5,
    parameter int CNT_LEN   = 16
);
    logic                 inst_valid;
    logic [INST_LEN-1:0]  inst;
    logic                 inst_ready;
    logic [ADDR_LEN-1:0]  mem_addr;
    logic                 mem_read;
    logic                 mem_write;
    logic [WORD_SIZE-1:0] mem_wdata;
    logic [WORD_SIZE-1:0] mem_rdata;
    logic [1:0]           alu_sig;
    logic [WORD_SIZE-1:0] alu_a;
    logic [WORD_SIZE-1:0] alu_b;
    logic [WORD_SIZE-1:0] alu_res;
    logic                 done;
    logic                 busy;
    logic [CNT_LEN-1:0]   retired_cnt;

    modport master (
        input  inst_valid, inst, mem_rdata, alu_res,
        output inst_ready, mem_addr, mem_read, mem_write, mem_wdata,
               alu_sig, alu_a, alu_b, done, busy, retired_cnt
    );

    modport slave (
        output inst_valid, inst, mem_rdata, alu_res,
        input  inst_ready, mem_addr, mem_read, mem_write, mem_wdata,
               alu_sig, alu_a, alu_b, done, busy, retired_cnt
    );
endinterface

// File: rtl/exec_seq_ctrl.sv
// exec_seq_ctrl: Moore sequencer issuing one instruction over a shared 1-cycle-latency memory port.
// Operand b only arrives from memory one cycle after RD2, so execute is split into EX1 (capture
// op_b) and EX2 (capture the ALU result of op_a and the new op_b). Latency is therefore
// RD1, RD2, EX1, EX2, WB: the write and counter increment happen 5 edges after accept, and
// under continuous inst_valid one instruction is accepted every 6 cycles.
module exec_seq_ctrl #(
    parameter int INST_LEN  = 17,
    parameter int WORD_SIZE = 32,
    parameter int ADDR_LEN  = 5,
    parameter int CNT_LEN   = 16
) (
    input logic        clk,
    input logic        rstn,
    exec_seq_if.master bus
);
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] RD1  = 3'd1;
    localparam logic [2:0] RD2  = 3'd2;
    localparam logic [2:0] EX1  = 3'd3;
    localparam logic [2:0] EX2  = 3'd4;
    localparam logic [2:0] WB   = 3'd5;

    logic [2:0]           state_q, state_d;
    logic [INST_LEN-1:0]  inst_q, inst_d;
    logic [WORD_SIZE-1:0] op_a_q, op_a_d;
    logic [WORD_SIZE-1:0] op_b_q, op_b_d;
    logic [WORD_SIZE-1:0] res_q, res_d;
    logic [CNT_LEN-1:0]   cnt_q, cnt_d;

    // Next state: fixed walk through the stages, waiting in IDLE for an offered instruction
    always_comb begin
        state_d = state_q == IDLE ? (bus.inst_valid ? RD1 : IDLE) :
                  state_q == RD1  ? RD2 :
                  state_q == RD2  ? EX1 :
                  state_q == EX1  ? EX2 :
                  state_q == EX2  ? WB  : IDLE;
        inst_d  = (state_q == IDLE && bus.inst_valid) ? bus.inst : inst_q;
        op_a_d  = state_q == RD2 ? bus.mem_rdata : op_a_q;
        op_b_d  = state_q == EX1 ? bus.mem_rdata : op_b_q;
        res_d   = state_q == EX2 ? bus.alu_res : res_q;
        cnt_d   = state_q == WB ? cnt_q + CNT_LEN'(1) : cnt_q;
    end

    // State registers, all cleared asynchronously so a mid-flight reset abandons the write
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            inst_q  <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            inst_q  <= inst_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs decode registered state only; inst_ready is additionally held low during reset
    always_comb begin
        bus.inst_ready  = rstn && state_q == IDLE;
        bus.busy        = state_q != IDLE;
        bus.mem_addr    = state_q == RD1 ? inst_q[14:10] :
                          state_q == RD2 ? inst_q[9:5]   :
                          state_q == WB  ? inst_q[4:0]   : '0;
        bus.mem_read    = state_q == RD1 || state_q == RD2;
        bus.mem_write   = state_q == WB;
        bus.mem_wdata   = res_q;
        bus.done        = state_q == WB;
        bus.alu_sig     = inst_q[16:15];
        bus.alu_a       = op_a_q;
        bus.alu_b       = op_b_q;
        bus.retired_cnt = cnt_q;
    end
endmodule

// File: tb/tb_exec_seq_ctrl.sv
// tb_exec_seq_ctrl: directed bench with memory and ALU models; a 2-bit-counter twin runs in lockstep
module tb_exec_seq_ctrl;
    logic        clk = 1'b0;
    logic        rstn;
    logic        inst_valid;
    logic [16:0] inst;
    logic [31:0] rdata;
    logic [31:0] mem [32];
    int          checks = 0;
    int          errors = 0;
    int          n_ret  = 0;

    always #5 clk = ~clk;

    exec_seq_if #(.CNT_LEN(16)) bus ();
    exec_seq_if #(.CNT_LEN(2))  bus2 ();

    exec_seq_ctrl #(.CNT_LEN(16)) dut  (.clk(clk), .rstn(rstn), .bus(bus));
    exec_seq_ctrl #(.CNT_LEN(2))  dut2 (.clk(clk), .rstn(rstn), .bus(bus2));

    function automatic logic [31:0] alu_f(input logic [1:0] s, input logic [31:0] a, input logic [31:0] b);
        return s == 2'b00 ? (a & b) : s == 2'b01 ? a + b : s == 2'b10 ? a - b : (a ^ b);
    endfunction

    assign bus.inst_valid  = inst_valid;
    assign bus.inst        = inst;
    assign bus.mem_rdata   = rdata;
    assign bus.alu_res     = alu_f(bus.alu_sig, bus.alu_a, bus.alu_b);
    assign bus2.inst_valid = inst_valid;
    assign bus2.inst       = inst;
    assign bus2.mem_rdata  = rdata;
    assign bus2.alu_res    = alu_f(bus2.alu_sig, bus2.alu_a, bus2.alu_b);

    always @(posedge clk) begin
        if (bus.mem_write) mem[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_read) rdata <= mem[bus.mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Runs one instruction from an IDLE negedge, scrambling inst every busy cycle
    task automatic run_inst(input logic [16:0] in, input logic [31:0] ea, input logic [31:0] eb, input logic [31:0] er);
        logic [4:0] o1, o2, d;
        o1 = in[14:10];
        o2 = in[9:5];
        d  = in[4:0];
        check("idle_ready", bus.inst_ready, 1);
        inst = in;
        inst_valid = 1'b1;
        @(negedge clk);
        inst_valid = 1'b0;
        inst = 17'($urandom);
        check("rd1_addr", bus.mem_addr, 32'(o1));
        check("rd1_read", bus.mem_read, 1);
        check("rd1_ready", bus.inst_ready, 0);
        check("rd1_busy", bus.busy, 1);
        check("alu_sig", bus.alu_sig, 32'(in[16:15]));
        @(negedge clk);
        inst = 17'($urandom);
        check("rd2_addr", bus.mem_addr, 32'(o2));
        check("rd2_read", bus.mem_read, 1);
        @(negedge clk);
        inst = 17'($urandom);
        check("ex1_alu_a", bus.alu_a, ea);
        check("ex1_port", {bus.mem_read, bus.mem_write, 27'(bus.mem_addr)}, 0);
        @(negedge clk);
        inst = 17'($urandom);
        check("ex2_alu_a", bus.alu_a, ea);
        check("ex2_alu_b", bus.alu_b, eb);
        check("ex2_done", bus.done, 0);
        @(negedge clk);
        check("wb_addr", bus.mem_addr, 32'(d));
        check("wb_write", bus.mem_write, 1);
        check("wb_wdata", bus.mem_wdata, er);
        check("wb_done", bus.done, 1);
        n_ret++;
        @(negedge clk);
        check("post_done", bus.done, 0);
        check("post_write", bus.mem_write, 0);
        check("post_busy", bus.busy, 0);
        check("wdata_hold", bus.mem_wdata, er);
        check("mem_dest", mem[d], er);
        check("cnt16", bus.retired_cnt, 32'(n_ret));
        check("cnt2", bus2.retired_cnt, 32'(n_ret % 4));
    endtask

    initial begin
        logic [16:0] b2b [4];
        rstn = 1'b0;
        inst_valid = 1'b0;
        inst = '0;
        rdata = '0;
        for (int i = 0; i < 32; i++) mem[i] = 32'h100 + 32'(i);
        mem[3] = 10;
        mem[7] = 5;
        mem[5] = 9;
        mem[1] = 100;
        mem[2] = 7;
        mem[30] = 32'hDEAD;
        repeat (2) @(negedge clk);
        check("rst_ready", bus.inst_ready, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_port", {bus.mem_read, bus.mem_write, 25'(bus.mem_addr)}, 0);
        check("rst_wdata", bus.mem_wdata, 0);
        check("rst_alu", {bus.alu_a | bus.alu_b}, 0);
        check("rst_done", bus.done, 0);
        check("rst_cnt", bus.retired_cnt, 0);
        rstn = 1'b1;
        #1;
        check("first_ready", bus.inst_ready, 1);
        @(negedge clk);
        run_inst({2'b01, 5'd3, 5'd7, 5'd12}, 10, 5, 15);
        run_inst({2'b01, 5'd5, 5'd5, 5'd5}, 9, 9, 18);
        b2b[0] = {2'b01, 5'd1, 5'd2, 5'd20};
        b2b[1] = {2'b10, 5'd1, 5'd2, 5'd21};
        b2b[2] = {2'b11, 5'd1, 5'd2, 5'd22};
        b2b[3] = {2'b00, 5'd1, 5'd2, 5'd23};
        inst_valid = 1'b1;
        for (int c = 0; c < 24; c++) begin
            inst = b2b[c / 6];
            check("b2b_ready", bus.inst_ready, 32'(c % 6 == 0));
            @(negedge clk);
        end
        inst_valid = 1'b0;
        n_ret += 4;
        check("b2b_add", mem[20], 107);
        check("b2b_sub", mem[21], 93);
        check("b2b_xor", mem[22], 99);
        check("b2b_and", mem[23], 4);
        check("b2b_cnt16", bus.retired_cnt, 32'(n_ret));
        check("b2b_cnt2", bus2.retired_cnt, 32'(n_ret % 4));
        inst = {2'b01, 5'd3, 5'd7, 5'd30};
        inst_valid = 1'b1;
        @(negedge clk);
        inst_valid = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b0;
        #1;
        check("mid_busy", bus.busy, 0);
        check("mid_ready", bus.inst_ready, 0);
        check("mid_port", {bus.mem_read, bus.mem_write, 25'(bus.mem_addr)}, 0);
        check("mid_alu", bus.alu_a | bus.alu_b, 0);
        check("mid_wdata", bus.mem_wdata, 0);
        check("mid_sig", bus.alu_sig, 0);
        check("mid_cnt", bus.retired_cnt, 0);
        n_ret = 0;
        repeat (3) @(negedge clk);
        check("mid_nowrite", mem[30], 32'hDEAD);
        rstn = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 5; k++)
            if (k % 2 == 0) run_inst({2'b01, 5'd3, 5'd7, 5'(24 + k)}, 10, 5, 15);
            else run_inst({2'b10, 5'd3, 5'd7, 5'(24 + k)}, 10, 5, 5);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
